// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default line format and line levels.
// Used by both the transmitter and the receiver so the two agree on framing.
package uart_pkg;

  // Frame-level states shared by transmitter and receiver.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Default line format: 8 data bits, 8 clocks per bit.
  localparam int UART_BITS         = 8;
  localparam int UART_CLKS_PER_BIT = 8;

  // Line levels: the line rests high, a frame opens low and closes high.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Total clock cycles occupied by one frame on the line.
  function automatic int frame_cycles(input int bits, input int clks_per_bit, input int stop_bits);
    return (1 + bits + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-cell timer: counts clocks inside one serial bit and flags the last one.
// The same block serves the receiver's sampler, so it knows nothing about frames.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  // A width of at least one bit keeps the counter legal for tiny cell sizes.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_r;

  // Cycle counter: held at zero while cleared, restarts at every bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (count_r == LAST) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

  // The boundary is the last cycle of the cell; suppressed while cleared.
  assign tick = (count_r == LAST) && !clear;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and sends
// start bit, BITS data bits MSB first, then STOP_BITS stop bits on tx.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BITS         = UART_BITS,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] data,
  input  logic            valid,
  output logic            ready,
  output logic            tx,
  output logic            busy
);

  localparam int            IW        = $clog2(BITS + 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e     state_r;
  logic [BITS-1:0] shift_r;
  logic [IW-1:0]   bit_idx_r;
  logic            stop_idx_r;
  logic            tx_r;
  logic            ready_r;
  logic            busy_r;
  logic            clear_s;
  logic            tick_s;

  // The timer idles at zero so the start bit gets a full cell after acceptance.
  assign clear_s = (state_r == IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(clear_s),
    .tick (tick_s)
  );

  // Frame sequencer: state, shift register, indices and all line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= {BITS{1'b0}};
      bit_idx_r  <= {IW{1'b0}};
      stop_idx_r <= 1'b0;
      tx_r       <= LINE_IDLE;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (valid && ready_r) begin
            shift_r    <= data;
            bit_idx_r  <= {IW{1'b0}};
            stop_idx_r <= 1'b0;
            tx_r       <= START_BIT;
            ready_r    <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= START;
          end else begin
            tx_r    <= LINE_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        START: begin
          if (tick_s) begin
            // First data bit goes out; the register moves up to expose the next.
            tx_r      <= shift_r[BITS-1];
            shift_r   <= {shift_r[BITS-2:0], 1'b0};
            bit_idx_r <= {IW{1'b0}};
            state_r   <= DATA;
          end else begin
            tx_r <= START_BIT;
          end
        end
        DATA: begin
          if (tick_s) begin
            if (bit_idx_r == LAST_BIT) begin
              tx_r       <= STOP_BIT;
              stop_idx_r <= 1'b0;
              state_r    <= STOP;
            end else begin
              tx_r      <= shift_r[BITS-1];
              shift_r   <= {shift_r[BITS-2:0], 1'b0};
              bit_idx_r <= bit_idx_r + IW'(1);
            end
          end else begin
            tx_r <= tx_r;
          end
        end
        STOP: begin
          if (tick_s) begin
            if (stop_idx_r == STOP_LAST) begin
              tx_r    <= LINE_IDLE;
              ready_r <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              stop_idx_r <= stop_idx_r + 1'b1;
            end
          end else begin
            tx_r <= STOP_BIT;
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= LINE_IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign tx    = tx_r;
  assign ready = ready_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a default instance (8 bits, 8 clocks/bit, 1 stop) and a
// narrow instance (7 bits, 3 clocks/bit, 2 stops), checked against a frame
// model computed from the line format plus a simple mid-bit receiver.
module tb_uart_tx;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data_a;
  logic       valid_a, ready_a, tx_a, busy_a;
  logic [6:0] data_b;
  logic       valid_b, ready_b, tx_b, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;
  int prev_start = 0;

  uart_tx dut_a (
    .clk(clk), .rst(rst), .data(data_a), .valid(valid_a),
    .ready(ready_a), .tx(tx_a), .busy(busy_a)
  );

  uart_tx #(.BITS(7), .CLKS_PER_BIT(3), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .data(data_b), .valid(valid_b),
    .ready(ready_b), .tx(tx_b), .busy(busy_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  function automatic logic get_ready(input bit sel);
    return sel ? ready_b : ready_a;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      valid_b = v;
      data_b  = d[6:0];
    end else begin
      valid_a = v;
      data_a  = d;
    end
  endtask

  // Called at a falling edge while the selected DUT is idle. Offers d, then
  // checks every frame cycle and the idle cycle that follows.
  task automatic run_frame(input bit sel, input logic [7:0] d, input bit hold,
                           input logic [7:0] next_d, input bit noise);
    int cpb, bits, len, idx;
    logic exp;
    logic [7:0] rx;
    logic [7:0] mask;
    cpb  = sel ? 3 : 8;
    bits = sel ? 7 : 8;
    mask = sel ? 8'h7F : 8'hFF;
    len  = frame_cycles(bits, cpb, sel ? 2 : 1);
    drive(sel, 1'b1, d);
    @(posedge clk);
    rx = 8'h00;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      idx = c / cpb;
      if (idx == 0) exp = START_BIT;
      else if (idx <= bits) exp = d[bits - idx];
      else exp = STOP_BIT;
      chk("tx_level", {31'd0, get_tx(sel)}, {31'd0, exp});
      chk("ready_low", {31'd0, get_ready(sel)}, 32'd0);
      chk("busy_high", {31'd0, get_busy(sel)}, 32'd1);
      if (idx >= 1 && idx <= bits && (c % cpb) == cpb / 2) rx = {rx[6:0], get_tx(sel)};
      if (c == 0) begin
        prev_start = last_start;
        last_start = cyc;
        if (hold) drive(sel, 1'b1, next_d);
        else drive(sel, 1'b0, d);
      end
      if (noise && c == 10) drive(sel, 1'b1, ~d);
      if (noise && c == 20) drive(sel, 1'b0, d);
    end
    chk("rx_word", {24'd0, rx}, {24'd0, d & mask});
    @(negedge clk);
    chk("idle_tx", {31'd0, get_tx(sel)}, 32'd1);
    chk("idle_ready", {31'd0, get_ready(sel)}, 32'd1);
    chk("idle_busy", {31'd0, get_busy(sel)}, 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    logic exp;
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);

    // Reset, then a long idle stretch on both instances.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_a", {29'd0, tx_a, ready_a, busy_a}, 32'h6);
    chk("reset_b", {29'd0, tx_b, ready_b, busy_b}, 32'h6);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_a", {29'd0, tx_a, ready_a, busy_a}, 32'h6);
      chk("idle_b", {29'd0, tx_b, ready_b, busy_b}, 32'h6);
    end

    // Single frame, then a second word with valid/data wiggled mid-frame.
    run_frame(1'b0, 8'h5C, 1'b0, 8'h00, 1'b0);
    run_frame(1'b0, 8'hA3, 1'b0, 8'h00, 1'b1);

    // Random words on both instances.
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom);
      run_frame(1'b0, rd, 1'b0, 8'h00, (i % 2) == 1);
    end
    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom_range(127, 0));
      run_frame(1'b1, rd, 1'b0, 8'h00, 1'b0);
    end

    // Back-to-back with valid held high: one idle cycle between frames.
    run_frame(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
    run_frame(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);
    chk("b2b_spacing", last_start - prev_start, 32'd81);

    // Abort: reset on frame cycle 30, which lies in the data bits.
    rd = 8'hC3;
    drive(1'b0, 1'b1, rd);
    @(posedge clk);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) drive(1'b0, 1'b0, rd);
      if (c == 29) begin
        exp = rd[8 - (c / 8)];
        chk("abort_pre_tx", {31'd0, tx_a}, {31'd0, exp});
        chk("abort_pre_busy", {31'd0, busy_a}, 32'd1);
      end
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx", {31'd0, tx_a}, 32'd1);
    chk("abort_ready", {31'd0, ready_a}, 32'd1);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    run_frame(1'b0, 8'h81, 1'b0, 8'h00, 1'b0);

    // Narrow instance: 3 clocks per bit, 2 stop bits, 30-cycle frame.
    run_frame(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    chk("sweep_len", frame_cycles(7, 3, 2), 32'd30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter. It is the upstream neighbour of the UART receiver: its `tx` output drives the receiver's `rx` input directly.
- Accepts one parallel word per valid/ready handshake.
- Serialises the word as: start bit (0), BITS data bits MSB first, STOP_BITS stop bits (1).
- Line format and bit timing match the receiver: 8 clocks per bit by default, MSB first, idle-high line.

Parameters:
BITS, 8, data word width
CLKS_PER_BIT, 8, clock cycles each serial bit is held on tx; must be >= 2
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
data  input  BITS  word to transmit; sampled only on handshake
valid  input  1  data is valid this cycle
ready  output  1  transmitter can accept a word this cycle
tx  output  1  serial line, idle high; registered output
busy  output  1  high from the cycle after acceptance until the last stop-bit cycle, inclusive

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; outputs are tx=1, ready=1, busy=0.
  - Counters and the shift register clear.
  - Reset mid-frame aborts the frame immediately. tx is 1 on the next cycle; no partial stop bit.
- States and transitions:
  - IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - tx=1, ready=1.
  - On valid && ready: latch data into the shift register, clear the bit-cell counter, go to START.
  - valid without ready is ignored; data is not held.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles, starting the cycle after acceptance.
- DATA:
  - Shift register MSB on tx for CLKS_PER_BIT cycles per bit; BITS bits total.
  - Bit index counter is $clog2(BITS+1) wide and counts 0..BITS-1.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Cycle counter:
  - Width $clog2(CLKS_PER_BIT).
  - Resets to 0 on each bit boundary; the bit boundary is where count == CLKS_PER_BIT-1.
  - No wrap beyond CLKS_PER_BIT-1.
- Frame timing:
  - Frame length is (1+BITS+STOP_BITS)*CLKS_PER_BIT cycles.
  - ready=0 for that entire span.
  - ready returns to 1 in the first IDLE cycle after the last stop cycle.
  - Back-to-back frames are therefore separated by exactly 1 idle-high cycle when valid is held high.
- ready is a registered function of state (ready=1 iff state==IDLE). It has no combinational path from valid.
- The input word is captured at acceptance. Changing data or valid during a frame has no effect.
- busy = state!=IDLE.

Decomposition:
- Shared package uart_pkg, also used by the receiver:
  - State enum (IDLE, START, DATA, STOP).
  - Default constants UART_BITS=8, UART_CLKS_PER_BIT=8.
  - Line levels LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
- One sub-module, uart_bit_timer:
  - Parameter CLKS_PER_BIT; inputs clk, rst, clear; output tick.
  - tick pulses on the last cycle of each bit cell.
  - Shareable with the receiver's sampler.

Test Plan:
- Reset then idle: rst high 2 cycles, valid=0 for 100 cycles -> tx=1, ready=1, busy=0 throughout.
- Single frame:
  - Stimulus: data=8'h5C (8'b01011100), valid pulsed 1 cycle in IDLE, defaults.
  - tx from the next cycle, each level held 8 cycles: 0 | 0,1,0,1,1,1,0,0 | 1.
  - ready=0 for 80 cycles, then 1.
- Loopback: tx wired to the UART receiver's rx; send 8'h5C, then 8'hA3 -> receiver data shows 8'h5C, then 8'hA3.
- Back-to-back: valid held high; data=8'h00, then 8'hFF after the first acceptance -> second start bit begins exactly 81 cycles after the first; exactly 1 idle-high cycle between frames.
- Abort: rst asserted on cycle 30 of a frame (during DATA) -> tx=1, ready=1 on the next cycle; a new frame with 8'h81 then transmits correctly.
- Parameter sweep: CLKS_PER_BIT=3, STOP_BITS=2, BITS=7, data=7'h55 -> each bit held 3 cycles; frame length 30 cycles; stop held 6 cycles.
